// File: rtl/bcd_convert_arbiter_if.sv
// Request/response bundle for bcd_convert_arbiter: NUM_REQ requesters in, one tagged BCD result out.
interface bcd_convert_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [5*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_bcd;
  logic                 out_error;
  logic [ID_W-1:0]      out_id;
  logic                 busy;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_bcd, out_error, out_id, busy
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_bcd, out_error, out_id, busy
  );
endinterface

// File: rtl/bcd_convert_arbiter.sv
// Round-robin arbiter sharing one 5-bit binary-to-BCD converter; one conversion in flight,
// registered two-digit result tagged with the owning requester id.
module binary_to_bcd (
  input  logic [4:0] bin,
  output logic [7:0] bcd,
  output logic       err
);
  always_comb begin
    bcd = '0;
    err = 1'b0;
    if (bin > 5'd29) begin
      err = 1'b1;
    end else if (bin >= 5'd20) begin
      bcd = {4'd2, 4'(bin - 5'd20)};
    end else if (bin >= 5'd10) begin
      bcd = {4'd1, 4'(bin - 5'd10)};
    end else begin
      bcd = {4'd0, bin[3:0]};
    end
  end
endmodule

module bcd_convert_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  bcd_convert_arbiter_if.slave        bus
);
  typedef enum logic [1:0] {IDLE, CONV, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] grant_sel;
  logic [ID_W-1:0] grant_id;
  logic [4:0]      grant_data;
  logic            grant_found;
  logic [4:0]      data_q;
  logic [7:0]      conv_bcd;
  logic            conv_err;

  binary_to_bcd u_conv (
    .bin (data_q),
    .bcd (conv_bcd),
    .err (conv_err)
  );

  // Search starts at rr_ptr and wraps; first valid index wins.
  always_comb begin
    int unsigned idx;
    grant_found = 1'b0;
    grant_sel   = '0;
    grant_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_ptr) + i) % NUM_REQ;
      if (!grant_found && bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_sel   = ID_W'(idx);
        grant_data  = bus.req_data[5*idx +: 5];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    bus.req_ready = '0;
    case (state_q)
      IDLE: begin
        if (grant_found && !rst) begin
          bus.req_ready[grant_sel] = 1'b1;
          state_d = CONV;
        end
      end
      CONV:    state_d = RESP;
      RESP:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr        <= '0;
      grant_id      <= '0;
      data_q        <= '0;
      bus.out_bcd   <= '0;
      bus.out_error <= 1'b0;
      bus.out_id    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && grant_found) begin
        data_q   <= grant_data;
        grant_id <= grant_sel;
      end
      if (state_q == CONV) begin
        bus.out_bcd   <= conv_bcd;
        bus.out_error <= conv_err;
        bus.out_id    <= grant_id;
        rr_ptr        <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
    end
  end

  assign bus.out_valid = (state_q == RESP);
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Directed bench for bcd_convert_arbiter: grant order, conversion values, backpressure and reset.
module tb_bcd_convert_arbiter;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  bcd_convert_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  bcd_convert_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] pack(input int d0, input int d1, input int d2, input int d3);
    return {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
  endfunction

  function automatic logic [7:0] golden_bcd(input int unsigned v);
    return (v > 29) ? 8'h00 : 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic do_reset();
    bus.req_valid = '1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 0);
    check("rst_valid", 32'(bus.out_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_bcd", 32'(bus.out_bcd), 0);
    check("rst_err", 32'(bus.out_error), 0);
    check("rst_id", 32'(bus.out_id), 0);
    rst = 1'b0;
    bus.req_valid = '0;
  endtask

  // Called at a negedge with the DUT in IDLE; g is the hand-derived grant.
  task automatic txn(input logic [3:0] vmask, input logic [19:0] data, input int unsigned g,
                     input int unsigned stall, input bit drop);
    logic [4:0]  v;
    logic [7:0]  eb;
    v  = data[5*g +: 5];
    eb = golden_bcd(32'(v));
    bus.req_valid = vmask;
    bus.req_data  = data;
    bus.out_ready = (stall == 0);
    #1;
    check("grant_ready", 32'(bus.req_ready), 32'(1) << g);
    check("idle_busy", 32'(bus.busy), 0);
    @(negedge clk);
    if (drop) bus.req_valid = '0;
    check("conv_valid", 32'(bus.out_valid), 0);
    check("conv_ready", 32'(bus.req_ready), 0);
    check("conv_busy", 32'(bus.busy), 1);
    @(negedge clk);
    check("resp_valid", 32'(bus.out_valid), 1);
    check("resp_bcd", 32'(bus.out_bcd), 32'(eb));
    check("resp_err", 32'(bus.out_error), (v > 29) ? 1 : 0);
    check("resp_id", 32'(bus.out_id), g);
    if (stall > 0) bus.req_valid = '1;
    for (int i = 0; i < int'(stall); i++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.out_valid), 1);
      check("stall_bcd", 32'(bus.out_bcd), 32'(eb));
      check("stall_err", 32'(bus.out_error), (v > 29) ? 1 : 0);
      check("stall_id", 32'(bus.out_id), g);
      check("stall_ready", 32'(bus.req_ready), 0);
    end
    if (stall > 0) begin
      bus.req_valid = '0;
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    check("post_valid", 32'(bus.out_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    // Single request
    txn(4'b0001, pack(23, 0, 0, 0), 0, 0, 1);

    // All valid: rotation 0,1,2,3,0
    do_reset();
    txn(4'b1111, pack(10, 11, 12, 13), 0, 0, 0);
    txn(4'b1111, pack(10, 11, 12, 13), 1, 0, 0);
    txn(4'b1111, pack(10, 11, 12, 13), 2, 0, 0);
    txn(4'b1111, pack(10, 11, 12, 13), 3, 0, 0);
    txn(4'b1111, pack(10, 11, 12, 13), 0, 0, 1);

    // Range edges (rr_ptr now 1)
    txn(4'b0010, pack(0, 31, 0, 0), 1, 0, 1);
    txn(4'b0100, pack(0, 0, 29, 0), 2, 0, 1);
    txn(4'b1000, pack(0, 0, 0, 0), 3, 0, 1);
    txn(4'b0101, pack(30, 0, 19, 0), 0, 0, 1);

    // Backpressure, others requesting during RESP
    txn(4'b0001, pack(17, 0, 0, 0), 0, 5, 1);

    // Reset during CONV drops the result and clears rr_ptr
    bus.req_valid = 4'b0100;
    bus.req_data  = pack(0, 0, 7, 0);
    #1;
    check("r5_grant", 32'(bus.req_ready), 32'h4);
    @(negedge clk);
    check("r5_conv_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    check("r5_valid", 32'(bus.out_valid), 0);
    check("r5_busy", 32'(bus.busy), 0);
    check("r5_ready", 32'(bus.req_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    check("r5_no_stale", 32'(bus.out_valid), 0);
    txn(4'b1100, pack(0, 0, 5, 9), 2, 0, 1);

    // Full sweep on every requester
    for (int r = 0; r < int'(NUM_REQ); r++) begin
      for (int v = 0; v < 32; v++) begin
        logic [19:0] d;
        d = '0;
        d[5*r +: 5] = 5'(v);
        txn(4'(1 << r), d, r, 0, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
